// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter between instruction fetch and load/store for a single
// byte-wide RAM port. MEM has fixed priority; each grant runs IDLE -> BUSY -> DONE.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_len,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  if_busy,
    output logic                  mem_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef struct packed {
        logic                  owner_mem;
        logic                  we;
        logic [2:0]            n;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0][7:0]       wdata;
    } xact_t;

    state_e                state_q, state_d;
    xact_t                 xact_q, xact_d;
    logic [2:0]            issued_q, issued_d;
    logic [2:0]            cap_q, cap_d;
    logic                  started_q, started_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic [3:0][7:0]       if_data_q, if_data_d;
    logic [3:0][7:0]       mem_rdata_q, mem_rdata_d;

    always_comb begin
        state_d     = state_q;
        xact_d      = xact_q;
        issued_d    = issued_q;
        cap_d       = cap_q;
        started_d   = started_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        if (rdy) begin
            case (state_q)
                IDLE: begin
                    ram_wr_d = 1'b0;
                    if (mem_req || if_req) begin
                        if (mem_req) begin
                            xact_d.owner_mem = 1'b1;
                            xact_d.we        = mem_we;
                            xact_d.addr      = mem_addr;
                            xact_d.wdata     = mem_wdata;
                            case (mem_len)
                                2'b00:   xact_d.n = 3'd1;
                                2'b01:   xact_d.n = 3'd2;
                                default: xact_d.n = 3'd4;
                            endcase
                            mem_rdata_d = '0;
                        end else begin
                            xact_d.owner_mem = 1'b0;
                            xact_d.we        = 1'b0;
                            xact_d.addr      = if_addr;
                            xact_d.wdata     = '0;
                            xact_d.n         = 3'd4;
                            if_data_d        = '0;
                        end
                        ram_a_d    = xact_d.addr;
                        ram_wr_d   = xact_d.we;
                        ram_dout_d = xact_d.wdata[0];
                        issued_d   = 3'd1;
                        cap_d      = 3'd0;
                        started_d  = 1'b0;
                        state_d    = BUSY;
                    end
                end
                BUSY: begin
                    started_d = 1'b1;
                    if (issued_q < xact_q.n) begin
                        ram_a_d    = xact_q.addr + ADDR_WIDTH'(issued_q);
                        ram_wr_d   = xact_q.we;
                        ram_dout_d = xact_q.wdata[issued_q[1:0]];
                        issued_d   = issued_q + 3'd1;
                    end else begin
                        ram_wr_d = 1'b0;
                    end
                    if (xact_q.we) begin
                        if (issued_q == xact_q.n)
                            state_d = DONE;
                    end else if (started_q) begin
                        // ram_din lags ram_a by one cycle, so capture starts on the second BUSY cycle
                        if (xact_q.owner_mem)
                            mem_rdata_d[cap_q[1:0]] = ram_din;
                        else
                            if_data_d[cap_q[1:0]] = ram_din;
                        cap_d = cap_q + 3'd1;
                        if (cap_q + 3'd1 == xact_q.n)
                            state_d = DONE;
                    end
                end
                DONE: begin
                    ram_wr_d = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            xact_q      <= '0;
            issued_q    <= '0;
            cap_q       <= '0;
            started_q   <= 1'b0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            xact_q      <= xact_d;
            issued_q    <= issued_d;
            cap_q       <= cap_d;
            started_q   <= started_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_done   = (state_q == DONE) && !xact_q.owner_mem;
    assign mem_done  = (state_q == DONE) &&  xact_q.owner_mem;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_busy   = if_req  & ~if_done;
    assign mem_busy  = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a 4 KB aliased byte RAM plus a shadow
// memory model that predicts latency, address sequence and assembled data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic        if_done, mem_done, ram_wr, if_busy, mem_busy;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic [7:0]  ram_dout, ram_din;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [0:4095];
    logic [7:0]  mdl [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;

    logic [31:0] tr_a  [0:15];
    logic        tr_wr [0:15];
    bit          tr_both, tr_wrong;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .if_busy(if_busy), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, frozen by rdy like the real one
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_a] <= pl_d;
        end else if (rdy) begin
            ram_din <= ram[ram_a[11:0]];
            if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    function automatic int nbytes(input bit is_mem, input logic [1:0] len);
        if (!is_mem) return 4;
        if (len == 2'b00) return 1;
        if (len == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int exp_lat(input bit we, input int n);
        return we ? n + 1 : n + 2;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr, input int n);
        logic [31:0] v = '0;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v | (32'(mdl[a[11:0]]) << (8 * k));
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            mdl[a[11:0]] = wd[8*k +: 8];
        end
    endtask

    // Runs one transaction and records what the DUT did; callers compare
    task automatic do_xact(input bit is_mem, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] data);
        lat  = -1;
        data = 'x;
        for (int k = 0; k < 16; k++) begin
            tr_a[k]  = 'x;
            tr_wr[k] = 1'bx;
        end
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 1; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            tr_a[k]  = ram_a;
            tr_wr[k] = ram_wr;
            if (k == 1) begin
                if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
                mem_len = 2'($urandom); mem_we = 1'($urandom);
            end
            if (if_done && mem_done) tr_both = 1'b1;
            if (if_done || mem_done) begin
                if (is_mem ? !mem_done : !if_done) tr_wrong = 1'b1;
                lat  = k;
                data = is_mem ? mem_rdata : if_data;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_len = 2'b00; if_addr = '0; mem_addr = '0; mem_wdata = '0;
        #2 rst = 1'b0;
        mem_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({ram_a, ram_wr, ram_dout} !== 41'd0) begin errors++;
            $display("FAIL reset_ram got a=%h wr=%b dout=%h expected 0", ram_a, ram_wr, ram_dout); end
        checks++; if ({if_data, mem_rdata} !== 64'd0) begin errors++;
            $display("FAIL reset_data got if=%h mem=%h expected 0", if_data, mem_rdata); end
        checks++; if ({if_done, mem_done, if_busy, mem_busy} !== 4'b0001) begin errors++;
            $display("FAIL reset_flags got %b expected 0001", {if_done, mem_done, if_busy, mem_busy}); end
        mem_req = 1'b0;
        // Preload RAM and shadow while still in reset
        for (int i = 0; i < 4096; i++) begin
            pl_d = (i < 4) ? ((i == 0) ? 8'h13 : (i == 1) ? 8'h05 : 8'h00) : 8'($urandom);
            pl_a = 12'(i);
            mdl[i] = pl_d;
            pl_en = 1'b1;
            @(negedge clk);
        end
        pl_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({if_done, mem_done, ram_wr} !== 3'b000) begin errors++;
            $display("FAIL reset_idle got %b expected 000", {if_done, mem_done, ram_wr}); end
    endtask

    task automatic test_if_fetch();
        int lat; logic [31:0] d;
        do_xact(1'b0, 1'b0, 2'b11, 32'h0000_1000, '0, lat, d);
        checks++; if (lat !== 6) begin errors++; $display("FAIL fetch_lat got %0d expected 6", lat); end
        checks++; if (d !== 32'h0000_0513) begin errors++; $display("FAIL fetch_data got %h expected 00000513", d); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (tr_a[k] !== 32'h0000_1000 + 32'(k - 1) || tr_wr[k] !== 1'b0) begin errors++;
                $display("FAIL fetch_addr k=%0d got a=%h wr=%b expected a=%h wr=0", k, tr_a[k], tr_wr[k], 32'h1000 + 32'(k - 1)); end
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] d;
        logic [31:0] exp_b;
        do_xact(1'b1, 1'b1, 2'b11, 32'h20, 32'hDEAD_BEEF, lat, d);
        model_store(32'h20, 32'hDEAD_BEEF, 4);
        checks++; if (lat !== 5) begin errors++; $display("FAIL store_lat got %0d expected 5", lat); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (tr_a[k] !== 32'h20 + 32'(k - 1) || tr_wr[k] !== 1'b1) begin errors++;
                $display("FAIL store_addr k=%0d got a=%h wr=%b expected a=%h wr=1", k, tr_a[k], tr_wr[k], 32'h20 + 32'(k - 1)); end
        end
        exp_b = 32'hDEAD_BEEF;
        checks++; if ({ram[35], ram[34], ram[33], ram[32]} !== exp_b) begin errors++;
            $display("FAIL store_ram got %h%h%h%h expected %h", ram[35], ram[34], ram[33], ram[32], exp_b); end
        do_xact(1'b1, 1'b0, 2'b11, 32'h20, '0, lat, d);
        checks++; if (lat !== 6) begin errors++; $display("FAIL load_lat got %0d expected 6", lat); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data got %h expected deadbeef", d); end
    endtask

    task automatic test_half_byte();
        int lat; logic [31:0] d;
        logic [7:0] n24, n22;
        do_xact(1'b1, 1'b0, 2'b01, 32'h21, '0, lat, d);
        checks++; if (lat !== 4) begin errors++; $display("FAIL half_lat got %0d expected 4", lat); end
        checks++; if (d !== 32'h0000_ADBE) begin errors++; $display("FAIL half_data got %h expected 0000adbe", d); end
        n22 = mdl[12'h22];
        n24 = mdl[12'h24];
        do_xact(1'b1, 1'b1, 2'b00, 32'h23, 32'hAABB_CC77, lat, d);
        model_store(32'h23, 32'hAABB_CC77, 1);
        checks++; if (lat !== 2) begin errors++; $display("FAIL bstore_lat got %0d expected 2", lat); end
        checks++; if ({ram[34], ram[35], ram[36]} !== {n22, 8'h77, n24}) begin errors++;
            $display("FAIL bstore_ram got %h %h %h expected %h 77 %h", ram[34], ram[35], ram[36], n22, n24); end
    endtask

    task automatic test_simultaneous();
        int mem_at = -1, if_at = -1;
        logic [31:0] md = 'x, exp_md;
        bit both = 1'b0, busy_bad = 1'b0;
        exp_md = exp_read(32'h20, 4);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b11; mem_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 1; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_done && mem_done) both = 1'b1;
            if (!if_done && if_busy !== 1'b1) busy_bad = 1'b1;
            if (mem_done) begin mem_at = k; md = mem_rdata; mem_req = 1'b0; end
            if (if_done) begin if_at = k; break; end
        end
        checks++; if (mem_at !== 6) begin errors++; $display("FAIL simul_mem_lat got %0d expected 6", mem_at); end
        checks++; if (md !== exp_md) begin errors++; $display("FAIL simul_mem_data got %h expected %h", md, exp_md); end
        checks++; if (if_at !== 13) begin errors++; $display("FAIL simul_if_lat got %0d expected 13", if_at); end
        checks++; if (if_data !== 32'h0000_0513) begin errors++; $display("FAIL simul_if_data got %h expected 00000513", if_data); end
        checks++; if ({both, busy_bad} !== 2'b00) begin errors++;
            $display("FAIL simul_flags got both=%b busy_drop=%b expected 0 0", both, busy_bad); end
        if_req = 1'b0;
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] d, exp_d;
        exp_d = exp_read(32'hFFFF_FFFE, 4);
        do_xact(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFE, '0, lat, d);
        checks++; if (lat !== 6 || d !== exp_d) begin errors++;
            $display("FAIL wrap_read got lat=%0d d=%h expected lat=6 d=%h", lat, d, exp_d); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (tr_a[k] !== 32'hFFFF_FFFE + 32'(k - 1)) begin errors++;
                $display("FAIL wrap_addr k=%0d got %h expected %h", k, tr_a[k], 32'hFFFF_FFFE + 32'(k - 1)); end
        end
    endtask

    task automatic test_rdy_stall();
        int lat; logic [31:0] d;
        fork
            do_xact(1'b1, 1'b1, 2'b11, 32'h40, 32'h1122_3344, lat, d);
            begin
                @(negedge clk);
                repeat (2) @(negedge clk);
                rdy = 1'b0;
                repeat (3) @(negedge clk);
                rdy = 1'b1;
            end
        join
        model_store(32'h40, 32'h1122_3344, 4);
        checks++; if (lat !== 8) begin errors++; $display("FAIL stall_lat got %0d expected 8", lat); end
        checks++; if ({ram[67], ram[66], ram[65], ram[64]} !== 32'h1122_3344) begin errors++;
            $display("FAIL stall_ram got %h%h%h%h expected 11223344", ram[67], ram[66], ram[65], ram[64]); end
    endtask

    task automatic test_rst_mid();
        int pulses = 0, lat; logic [31:0] d, exp_d;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0; if_req = 1'b0;
        #1;
        checks++; if ({if_done, mem_done, ram_wr, ram_a, ram_dout} !== 43'd0) begin errors++;
            $display("FAIL rst_mid_out got done=%b%b wr=%b a=%h dout=%h expected 0", if_done, mem_done, ram_wr, ram_a, ram_dout); end
        checks++; if ({if_data, mem_rdata} !== 64'd0) begin errors++;
            $display("FAIL rst_mid_data got if=%h mem=%h expected 0", if_data, mem_rdata); end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin @(negedge clk); if (if_done || mem_done) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_pulse got %0d expected 0", pulses); end
        exp_d = exp_read(32'h100, 4);
        do_xact(1'b0, 1'b0, 2'b11, 32'h100, '0, lat, d);
        checks++; if (lat !== 6 || d !== exp_d) begin errors++;
            $display("FAIL rst_recover got lat=%0d d=%h expected lat=6 d=%h", lat, d, exp_d); end
    endtask

    task automatic test_random();
        int lat, n, bad = 0;
        bit is_mem, we;
        logic [1:0] len;
        logic [31:0] addr, wd, d, exp_d;
        tr_both = 1'b0; tr_wrong = 1'b0;
        for (int i = 0; i < 40; i++) begin
            is_mem = 1'($urandom);
            we     = is_mem ? 1'($urandom) : 1'b0;
            len    = 2'($urandom);
            addr   = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 4095));
            wd     = $urandom;
            n      = nbytes(is_mem, len);
            exp_d  = we ? 32'd0 : exp_read(addr, n);
            do_xact(is_mem, we, len, addr, wd, lat, d);
            if (we) model_store(addr, wd, n);
            checks++; if (lat !== exp_lat(we, n)) begin errors++;
                $display("FAIL rand_lat i=%0d got %0d expected %0d", i, lat, exp_lat(we, n)); end
            if (!we) begin
                checks++; if (d !== exp_d) begin errors++;
                    $display("FAIL rand_data i=%0d got %h expected %h", i, d, exp_d); end
            end
            for (int k = 1; k <= n; k++) begin
                checks++;
                if (tr_a[k] !== addr + 32'(k - 1) || tr_wr[k] !== we) begin errors++;
                    $display("FAIL rand_addr i=%0d k=%0d got a=%h wr=%b expected a=%h wr=%b", i, k, tr_a[k], tr_wr[k], addr + 32'(k - 1), we); end
            end
        end
        checks++; if ({tr_both, tr_wrong} !== 2'b00) begin errors++;
            $display("FAIL rand_done_owner got both=%b wrong=%b expected 0 0", tr_both, tr_wrong); end
        for (int i = 0; i < 4096; i++) if (ram[i] !== mdl[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_ram got %0d bad bytes expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_store_load();
        test_half_byte();
        test_simultaneous();
        test_wrap();
        test_rdy_stall();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM). Each granted request is serialised into 1, 2 or 4 sequential byte accesses, and the arbiter returns a one-cycle done pulse with the assembled little-endian word. Its busy outputs feed the core's stall logic so that a stage waiting on memory holds the pipeline.

## Interface
- ADDR_WIDTH, 32, width of every address bus

- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, every register holds (RAM is frozen by the same signal)
- if_req  in  1  IF requests a 4-byte read
- if_addr  in  ADDR_WIDTH  instruction address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction word
- mem_req  in  1  MEM requests an access
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word)
- mem_addr  in  ADDR_WIDTH  base byte address
- mem_wdata  in  32  store data, byte k = mem_wdata[8k+7:8k]
- mem_done  out  1  one-cycle pulse, access complete / mem_rdata valid
- mem_rdata  out  32  load data, zero-extended (sign extension is done in MEM)
- ram_a  out  ADDR_WIDTH  RAM byte address (registered)
- ram_wr  out  1  RAM write strobe (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte, valid one cycle after its address
- if_busy  out  1  combinational, if_req & ~if_done
- mem_busy  out  1  combinational, mem_req & ~mem_done

## Operation
- States: IDLE, BUSY, DONE. Reset (rst low, asynchronous) forces IDLE and zeroes all registered outputs, if_data, mem_rdata, the counters and the grant. A transaction in flight is discarded and requesters must re-request.
- IDLE: samples the requests. mem_req has fixed priority over if_req. On a grant the arbiter latches the owner, addr, we, wdata and N. N is 4 for IF, and 1/2/4 for MEM from mem_len. The read buffer is cleared, byte 0 is issued (ram_a=addr, ram_wr=we, ram_dout=wdata[7:0]), issue count = 1, and the state goes to BUSY.
- BUSY, each enabled edge:
  - If issue count < N: issue byte k (ram_a = addr+k, 32-bit wrap-around, ram_wr = we, ram_dout = wdata byte k). Otherwise ram_wr=0.
  - On a read, capture ram_din into buffer byte (issued-1 of the previous cycle), i.e. the byte addressed one cycle earlier.
  - Leave BUSY when all N bytes are issued (write) or captured (read).
- DONE: lasts one cycle. The owner's done output is 1. Its data output holds the buffer (bytes ≥ N are zero) and stays stable until the next grant to that owner. ram_wr=0. Requests are ignored in this cycle, and the state goes to IDLE.
- Requester rules:
  - Hold req high until done.
  - Deassert req no later than the edge ending the DONE cycle.
  - Input changes after the grant are ignored, because the latched copy is used.
  - Dropping req mid-BUSY is a protocol violation. The access still completes and done still pulses.
- rdy low: state, counters, buffer and all registered outputs hold. Combinational busy outputs still follow their inputs.
- ram_a holds its last value outside BUSY and is only meaningful while BUSY.

## Timing
- Grant sampled at the edge ending cycle T (IDLE, req high). Byte k address is on ram_a in cycle T+1+k.
- Read: byte k is on ram_din in cycle T+2+k and is captured at that edge. DONE is cycle T+N+2.
  - Word read: done in T+6.
  - Byte read: done in T+3.
- Write: last strobe in cycle T+N, DONE in T+N+1. Word store: done in T+5.
- Back-to-back: the earliest next grant is sampled in the IDLE cycle right after DONE, so there is a minimum 2-cycle gap between the end of one access and the next first address.
- Simultaneous if_req and mem_req in IDLE: MEM is granted, IF waits, and if_busy stays 1 throughout.
- done never asserts outside DONE. if_done and mem_done are never high together.

## Test plan
- IF fetch at 0x0000_1000, RAM bytes 13,05,00,00: done in T+6, if_data=0x0000_0513. ram_a steps 0x1000..0x1003 in T+1..T+4, ram_wr=0 throughout.
- MEM word store 0xDEADBEEF at 0x20, then word load at 0x20: four writes EF,BE,AD,DE to 0x20..0x23, mem_done in T+5. The load returns 0xDEADBEEF.
- MEM half load (len=01) at 0x21 after the store above: mem_rdata=0x0000_ADBE in T+4. Byte store 0x77 at 0x23 writes only 0x23.
- if_req and mem_req both raised in the same IDLE cycle: MEM served first. IF is granted in the IDLE cycle following mem_done, and if_busy is 1 until if_done.
- Word read at 0xFFFF_FFFE: ram_a wraps 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
- rst low for 1 cycle mid-read at T+3 → state IDLE, all outputs 0, no done pulse. rdy held low 3 cycles mid-store → done is delayed exactly 3 cycles and the stored bytes are unchanged.
